// File: rtl/order_book_matcher_pkg.sv
// Shared definitions for the order book matcher: FSM states and order side encodings.
package order_book_matcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MATCH  = 2'd1,
    ST_INSERT = 2'd2
  } state_e;

  localparam logic SIDE_BUY  = 1'b0;
  localparam logic SIDE_SELL = 1'b1;

endpackage

// File: rtl/order_book_matcher_if.sv
// Order entry, trade report and book status bundle between order source and matcher.
interface order_book_matcher_if #(
  parameter int PRICE_W = 8,
  parameter int QTY_W   = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic               in_valid;
  logic               in_ready;
  logic               in_side;
  logic [PRICE_W-1:0] in_price;
  logic [QTY_W-1:0]   in_qty;
  logic               halt;

  logic               trade_valid;
  logic [PRICE_W-1:0] trade_price;
  logic [QTY_W-1:0]   trade_qty;
  logic               trade_side;
  logic               reject;

  logic [PRICE_W-1:0] best_bid;
  logic [PRICE_W-1:0] best_ask;
  logic [CW-1:0]      bid_cnt;
  logic [CW-1:0]      ask_cnt;
  logic [PRICE_W-1:0] spread;
  logic [CNT_W-1:0]   trade_count;

  modport master (
    output in_valid, in_side, in_price, in_qty, halt,
    input  in_ready, trade_valid, trade_price, trade_qty, trade_side, reject,
    input  best_bid, best_ask, bid_cnt, ask_cnt, spread, trade_count
  );

  modport slave (
    input  in_valid, in_side, in_price, in_qty, halt,
    output in_ready, trade_valid, trade_price, trade_qty, trade_side, reject,
    output best_bid, best_ask, bid_cnt, ask_cnt, spread, trade_count
  );
endinterface

// File: rtl/order_book_matcher_side_book.sv
// One side of the book: DEPTH sorted entries kept packed toward index 0 (best first).
// DESCENDING=1 sorts bids high-to-low, 0 sorts asks low-to-high; equal prices keep arrival order.
module order_book_matcher_side_book #(
  parameter bit DESCENDING = 1'b1,
  parameter int PRICE_W    = 8,
  parameter int QTY_W      = 4,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       insert_i,
  input  logic [PRICE_W-1:0]         ins_price_i,
  input  logic [QTY_W-1:0]           ins_qty_i,
  input  logic                       dec_front_i,
  input  logic [QTY_W-1:0]           dec_qty_i,
  input  logic                       pop_front_i,
  output logic [PRICE_W-1:0]         front_price_o,
  output logic [QTY_W-1:0]           front_qty_o,
  output logic                       front_valid_o,
  output logic                       full_o,
  output logic [PRICE_W-1:0]         nxt_front_price_o,
  output logic                       nxt_front_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] nxt_count_o
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PRICE_W-1:0] price_q [DEPTH];
  logic [PRICE_W-1:0] price_d [DEPTH];
  logic [QTY_W-1:0]   qty_q   [DEPTH];
  logic [QTY_W-1:0]   qty_d   [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [DEPTH-1:0]   valid_d;
  logic [CW-1:0]      ins_pos;

  always_comb begin
    // NOTE: defaults first so every path assigns every bit; anything left unassigned would infer a latch.
    price_d = price_q;
    qty_d   = qty_q;
    valid_d = valid_q;
    ins_pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (DESCENDING ? (price_q[i] >= ins_price_i) : (price_q[i] <= ins_price_i)))
        ins_pos = ins_pos + CW'(1);
    end

    if (pop_front_i) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        price_d[i] = price_q[i+1];
        qty_d[i]   = qty_q[i+1];
        valid_d[i] = valid_q[i+1];
      end
      price_d[DEPTH-1] = '0;
      qty_d[DEPTH-1]   = '0;
      valid_d[DEPTH-1] = 1'b0;
    end else if (dec_front_i) begin
      qty_d[0] = qty_q[0] - dec_qty_i;
    end else if (insert_i && !valid_q[DEPTH-1]) begin
      // Entries at or after the slot slide one place toward the tail.
      for (int i = DEPTH - 1; i > 0; i--) begin
        if (CW'(i) > ins_pos) begin
          price_d[i] = price_q[i-1];
          qty_d[i]   = qty_q[i-1];
          valid_d[i] = valid_q[i-1];
        end else if (CW'(i) == ins_pos) begin
          price_d[i] = ins_price_i;
          qty_d[i]   = ins_qty_i;
          valid_d[i] = 1'b1;
        end
      end
      if (ins_pos == '0) begin
        price_d[0] = ins_price_i;
        qty_d[0]   = ins_qty_i;
        valid_d[0] = 1'b1;
      end
    end
  end

  always_comb begin
    nxt_count_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_d[i]) nxt_count_o = nxt_count_o + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the entry array is cleared on reset rather than left as plain storage: valid bits must
      // clear and the front price and quantity feed the status outputs directly.
      for (int i = 0; i < DEPTH; i++) begin
        price_q[i] <= '0;
        qty_q[i]   <= '0;
      end
      valid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples values from before the edge.
      price_q <= price_d;
      qty_q   <= qty_d;
      valid_q <= valid_d;
    end
  end

  assign front_price_o     = price_q[0];
  assign front_qty_o       = qty_q[0];
  assign front_valid_o     = valid_q[0];
  assign full_o            = valid_q[DEPTH-1];
  assign nxt_front_price_o = price_d[0];
  assign nxt_front_valid_o = valid_d[0];

endmodule

// File: rtl/order_book_matcher.sv
// Price-time priority matcher: an accepted order fills against the opposite book one fill per cycle,
// then any remainder rests in its own book. Trades, rejects and book status are registered outputs.
module order_book_matcher
  import order_book_matcher_pkg::*;
#(
  parameter int PRICE_W = 8,
  parameter int QTY_W   = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
) (
  input logic                  clk,
  input logic                  reset,
  order_book_matcher_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PRICE_W-1:0] EMPTY_ASK = '1;

  state_e             state_q, state_d;
  logic               side_q, side_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic               ready_en_q;
  logic               trade_valid_q, trade_valid_d;
  logic [PRICE_W-1:0] trade_price_q, trade_price_d;
  logic [QTY_W-1:0]   trade_qty_q, trade_qty_d;
  logic               trade_side_q, trade_side_d;
  logic               reject_q, reject_d;
  logic [CNT_W-1:0]   trade_count_q, trade_count_d;
  logic [PRICE_W-1:0] best_bid_q, best_bid_d, best_ask_q, best_ask_d, spread_q, spread_d;
  logic [CW-1:0]      bid_cnt_q, bid_cnt_d, ask_cnt_q, ask_cnt_d;

  logic               bid_ins, ask_ins, bid_dec, ask_dec, bid_pop, ask_pop;
  logic [PRICE_W-1:0] bid_price, ask_price, bid_nxt_price, ask_nxt_price;
  logic [QTY_W-1:0]   bid_qty, ask_qty;
  logic               bid_valid, ask_valid, bid_full, ask_full, bid_nxt_valid, ask_nxt_valid;

  logic               in_ready, accept, crossable, own_full, opp_valid;
  logic [PRICE_W-1:0] opp_price;
  logic [QTY_W-1:0]   opp_qty, fill;

  order_book_matcher_side_book #(
    .DESCENDING(1'b1), .PRICE_W(PRICE_W), .QTY_W(QTY_W), .DEPTH(DEPTH)
  ) u_bid_book (
    .clk, .reset,
    .insert_i(bid_ins), .ins_price_i(price_q), .ins_qty_i(qty_q),
    .dec_front_i(bid_dec), .dec_qty_i(fill), .pop_front_i(bid_pop),
    .front_price_o(bid_price), .front_qty_o(bid_qty), .front_valid_o(bid_valid), .full_o(bid_full),
    .nxt_front_price_o(bid_nxt_price), .nxt_front_valid_o(bid_nxt_valid), .nxt_count_o(bid_cnt_d)
  );

  order_book_matcher_side_book #(
    .DESCENDING(1'b0), .PRICE_W(PRICE_W), .QTY_W(QTY_W), .DEPTH(DEPTH)
  ) u_ask_book (
    .clk, .reset,
    .insert_i(ask_ins), .ins_price_i(price_q), .ins_qty_i(qty_q),
    .dec_front_i(ask_dec), .dec_qty_i(fill), .pop_front_i(ask_pop),
    .front_price_o(ask_price), .front_qty_o(ask_qty), .front_valid_o(ask_valid), .full_o(ask_full),
    .nxt_front_price_o(ask_nxt_price), .nxt_front_valid_o(ask_nxt_valid), .nxt_count_o(ask_cnt_d)
  );

  // ready_en_q holds acceptance off until the first edge after reset release.
  assign in_ready  = (state_q == ST_IDLE) && !bus.halt && ready_en_q;
  assign accept    = bus.in_valid && in_ready;
  assign opp_valid = (side_q == SIDE_BUY) ? ask_valid : bid_valid;
  assign opp_price = (side_q == SIDE_BUY) ? ask_price : bid_price;
  assign opp_qty   = (side_q == SIDE_BUY) ? ask_qty   : bid_qty;
  assign own_full  = (side_q == SIDE_BUY) ? bid_full  : ask_full;
  assign crossable = opp_valid && ((side_q == SIDE_BUY) ? (price_q >= opp_price) : (price_q <= opp_price));
  assign fill      = (qty_q < opp_qty) ? qty_q : opp_qty;

  always_comb begin
    state_d       = state_q;
    side_d        = side_q;
    price_d       = price_q;
    qty_d         = qty_q;
    trade_valid_d = 1'b0;
    trade_price_d = trade_price_q;
    trade_qty_d   = trade_qty_q;
    trade_side_d  = trade_side_q;
    reject_d      = 1'b0;
    trade_count_d = trade_count_q;
    bid_ins = 1'b0; ask_ins = 1'b0;
    bid_dec = 1'b0; ask_dec = 1'b0;
    bid_pop = 1'b0; ask_pop = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          side_d  = bus.in_side;
          price_d = bus.in_price;
          qty_d   = bus.in_qty;
          if (bus.in_qty == '0) reject_d = 1'b1;
          else                  state_d  = ST_MATCH;
        end
      end
      ST_MATCH: begin
        if (crossable) begin
          trade_valid_d = 1'b1;
          trade_price_d = opp_price;
          trade_qty_d   = fill;
          trade_side_d  = side_q;
          if (trade_count_q != '1) trade_count_d = trade_count_q + CNT_W'(1);
          if (side_q == SIDE_BUY) begin
            ask_pop = (fill == opp_qty);
            ask_dec = (fill != opp_qty);
          end else begin
            bid_pop = (fill == opp_qty);
            bid_dec = (fill != opp_qty);
          end
          qty_d = qty_q - fill;
          if (qty_d == '0) state_d = ST_IDLE;
        end else begin
          state_d = ST_INSERT;
        end
      end
      ST_INSERT: begin
        state_d = ST_IDLE;
        if (own_full)                reject_d = 1'b1;
        else if (side_q == SIDE_BUY) bid_ins  = 1'b1;
        else                         ask_ins  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status tracks the books' next contents so it is current right after each modifying edge.
  assign best_bid_d = bid_nxt_valid ? bid_nxt_price : '0;
  assign best_ask_d = ask_nxt_valid ? ask_nxt_price : EMPTY_ASK;
  assign spread_d   = (bid_nxt_valid && ask_nxt_valid) ? (ask_nxt_price - bid_nxt_price) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      side_q        <= SIDE_BUY;
      price_q       <= '0;
      qty_q         <= '0;
      ready_en_q    <= 1'b0;
      trade_valid_q <= 1'b0;
      trade_price_q <= '0;
      trade_qty_q   <= '0;
      trade_side_q  <= 1'b0;
      reject_q      <= 1'b0;
      trade_count_q <= '0;
      best_bid_q    <= '0;
      best_ask_q    <= EMPTY_ASK;
      spread_q      <= '0;
      bid_cnt_q     <= '0;
      ask_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      side_q        <= side_d;
      price_q       <= price_d;
      qty_q         <= qty_d;
      ready_en_q    <= 1'b1;
      trade_valid_q <= trade_valid_d;
      trade_price_q <= trade_price_d;
      trade_qty_q   <= trade_qty_d;
      trade_side_q  <= trade_side_d;
      reject_q      <= reject_d;
      trade_count_q <= trade_count_d;
      best_bid_q    <= best_bid_d;
      best_ask_q    <= best_ask_d;
      spread_q      <= spread_d;
      bid_cnt_q     <= bid_cnt_d;
      ask_cnt_q     <= ask_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.trade_valid = trade_valid_q;
  assign bus.trade_price = trade_price_q;
  assign bus.trade_qty   = trade_qty_q;
  assign bus.trade_side  = trade_side_q;
  assign bus.reject      = reject_q;
  assign bus.best_bid    = best_bid_q;
  assign bus.best_ask    = best_ask_q;
  assign bus.bid_cnt     = bid_cnt_q;
  assign bus.ask_cnt     = ask_cnt_q;
  assign bus.spread      = spread_q;
  assign bus.trade_count = trade_count_q;

endmodule

// File: tb/tb_order_book_matcher.sv
// Directed and random orders against a queue-based price-time priority model of both books.
module tb_order_book_matcher;
  import order_book_matcher_pkg::*;

  localparam int PRICE_W = 8;
  localparam int QTY_W   = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int WINDOW  = DEPTH + 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  order_book_matcher_if #(.PRICE_W(PRICE_W), .QTY_W(QTY_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  order_book_matcher #(.PRICE_W(PRICE_W), .QTY_W(QTY_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { int price; int qty; } entry_t;
  typedef struct { int price; int qty; int side; int cyc; } trade_t;

  entry_t bids[$];
  entry_t asks[$];
  trade_t exp_tr[$];
  trade_t obs_tr[$];
  int     exp_rej;
  int     obs_rej;
  int     model_count;
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: fill against the opposite queue front, then rest the remainder after equal prices.
  task automatic model_order(input int side, input int price, input int qty);
    int rem, f, idx;
    entry_t e;
    exp_tr.delete();
    exp_rej = 0;
    if (qty == 0) begin
      exp_rej = 1;
      return;
    end
    rem = qty;
    if (side == 0) begin
      while (rem > 0 && asks.size() > 0 && price >= asks[0].price) begin
        e = asks[0];
        f = (rem < e.qty) ? rem : e.qty;
        exp_tr.push_back('{price: e.price, qty: f, side: 0, cyc: 0});
        e.qty -= f;
        rem   -= f;
        if (e.qty == 0) void'(asks.pop_front()); else asks[0] = e;
        if (model_count < 255) model_count++;
      end
      if (rem > 0) begin
        if (bids.size() == DEPTH) exp_rej = 1;
        else begin
          idx = 0;
          while (idx < bids.size() && bids[idx].price >= price) idx++;
          bids.insert(idx, '{price: price, qty: rem});
        end
      end
    end else begin
      while (rem > 0 && bids.size() > 0 && price <= bids[0].price) begin
        e = bids[0];
        f = (rem < e.qty) ? rem : e.qty;
        exp_tr.push_back('{price: e.price, qty: f, side: 1, cyc: 0});
        e.qty -= f;
        rem   -= f;
        if (e.qty == 0) void'(bids.pop_front()); else bids[0] = e;
        if (model_count < 255) model_count++;
      end
      if (rem > 0) begin
        if (asks.size() == DEPTH) exp_rej = 1;
        else begin
          idx = 0;
          while (idx < asks.size() && asks[idx].price <= price) idx++;
          asks.insert(idx, '{price: price, qty: rem});
        end
      end
    end
  endtask

  task automatic check_status(input string tag);
    int eb, ea, es;
    eb = (bids.size() > 0) ? bids[0].price : 0;
    ea = (asks.size() > 0) ? asks[0].price : 255;
    es = (bids.size() > 0 && asks.size() > 0) ? ea - eb : 0;
    check({tag, "_best_bid"},    32'(bus.best_bid),    eb);
    check({tag, "_best_ask"},    32'(bus.best_ask),    ea);
    check({tag, "_bid_cnt"},     32'(bus.bid_cnt),     bids.size());
    check({tag, "_ask_cnt"},     32'(bus.ask_cnt),     asks.size());
    check({tag, "_spread"},      32'(bus.spread),      es);
    check({tag, "_trade_count"}, 32'(bus.trade_count), model_count);
  endtask

  task automatic send_order(input string tag, input int side, input int price, input int qty,
                            input bit halt_mid);
    int wait_cyc;
    bit saw_ready;
    model_order(side, price, qty);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_side  = side[0];
    bus.in_price = 8'(price);
    bus.in_qty   = 4'(qty);
    wait_cyc = 0;
    while (!bus.in_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check({tag, "_ready_wait"}, 32'(bus.in_ready), 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    if (halt_mid) bus.halt = 1'b1;
    obs_tr.delete();
    obs_rej   = 0;
    saw_ready = 1'b0;
    for (int k = 1; k <= WINDOW; k++) begin
      @(negedge clk);
      if (bus.trade_valid)
        obs_tr.push_back('{price: int'(bus.trade_price), qty: int'(bus.trade_qty),
                           side: int'(bus.trade_side), cyc: k});
      if (bus.reject) obs_rej++;
      if (bus.in_ready) saw_ready = 1'b1;
    end
    if (halt_mid) begin
      check({tag, "_halt_ready"}, 32'(saw_ready), 0);
      bus.halt = 1'b0;
    end
    check({tag, "_trade_n"}, obs_tr.size(), exp_tr.size());
    for (int i = 0; i < obs_tr.size() && i < exp_tr.size(); i++) begin
      check($sformatf("%s_t%0d_price", tag, i), obs_tr[i].price, exp_tr[i].price);
      check($sformatf("%s_t%0d_qty",   tag, i), obs_tr[i].qty,   exp_tr[i].qty);
      check($sformatf("%s_t%0d_side",  tag, i), obs_tr[i].side,  exp_tr[i].side);
      // First fill is visible two cycles after the accept edge, later fills back to back.
      check($sformatf("%s_t%0d_cyc",   tag, i), obs_tr[i].cyc,   2 + i);
    end
    check({tag, "_reject"}, obs_rej, exp_rej);
    check_status(tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bids.delete();
    asks.delete();
    model_count = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bus.in_valid = 1'b0;
    bus.in_side  = 1'b0;
    bus.in_price = '0;
    bus.in_qty   = '0;
    bus.halt     = 1'b0;
    model_count  = 0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_trade_valid", 32'(bus.trade_valid), 0);
    check("rst_reject",      32'(bus.reject),      0);
    check("rst_trade_price", 32'(bus.trade_price), 0);
    check("rst_trade_qty",   32'(bus.trade_qty),   0);
    check("rst_trade_side",  32'(bus.trade_side),  0);
    check_status("rst");
    reset = 1'b0;
    #1 check("rst_ready_before_edge", 32'(bus.in_ready), 0);

    // Single buy on empty books rests.
    send_order("t1", 0, 50, 3, 1'b0);
    check("t1_bid50", 32'(bus.best_bid), 50);
    check("t1_askFF", 32'(bus.best_ask), 255);

    // Partial fill then remainder rests as a bid.
    apply_reset();
    send_order("t2a", 1, 60, 2, 1'b0);
    send_order("t2b", 0, 65, 5, 1'b0);
    check("t2_bid65", 32'(bus.best_bid), 65);
    check("t2_ask_cnt", 32'(bus.ask_cnt), 0);

    // Sweep three ask levels with back-to-back fills.
    apply_reset();
    send_order("t3a", 1, 60, 1, 1'b0);
    send_order("t3b", 1, 61, 1, 1'b0);
    send_order("t3c", 1, 62, 1, 1'b0);
    send_order("t3d", 0, 70, 3, 1'b0);
    check("t3_count3", 32'(bus.trade_count), 3);

    // Time priority at equal price; the leftover of B is then hit by a later sell.
    apply_reset();
    send_order("t4a", 0, 55, 1, 1'b0);
    send_order("t4b", 0, 55, 2, 1'b0);
    send_order("t4c", 1, 50, 2, 1'b0);
    send_order("t4d", 1, 55, 2, 1'b0);

    // Full bid book rejects a further non-crossing bid; zero quantity rejects.
    apply_reset();
    send_order("t5a", 0, 20, 1, 1'b0);
    send_order("t5b", 0, 30, 1, 1'b0);
    send_order("t5c", 0, 40, 1, 1'b0);
    send_order("t5d", 0, 50, 1, 1'b0);
    send_order("t5e", 0, 10, 1, 1'b0);
    check("t5_bid_cnt_full", 32'(bus.bid_cnt), DEPTH);
    send_order("t5f", 1, 45, 0, 1'b0);

    // Halt raised during a multi-fill sequence.
    apply_reset();
    send_order("t6a", 1, 60, 1, 1'b0);
    send_order("t6b", 1, 61, 1, 1'b0);
    send_order("t6c", 1, 62, 1, 1'b0);
    send_order("t6d", 0, 70, 3, 1'b1);

    // Reset while the aggressor is in its first match cycle.
    apply_reset();
    send_order("t7a", 1, 60, 1, 1'b0);
    send_order("t7b", 1, 61, 1, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_side  = 1'b0;
    bus.in_price = 8'd70;
    bus.in_qty   = 4'd2;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bids.delete();
    asks.delete();
    model_count = 0;
    seen = 0;
    repeat (WINDOW) begin
      @(negedge clk);
      if (bus.trade_valid || bus.reject) seen++;
    end
    check("t7_no_pulse", seen, 0);
    check_status("t7");

    // Random traffic around a common price band.
    apply_reset();
    for (int n = 0; n < 150; n++) begin
      int s, p, q;
      s = int'($urandom_range(0, 1));
      p = 40 + int'($urandom_range(0, 30));
      q = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
      send_order($sformatf("r%0d", n), s, p, q, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
